// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES key-schedule controller: FSM states, round and column counts.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, UPDATE, DONE} ctrl_state_e;

    localparam int unsigned NR128 = 10;
    localparam int unsigned NR256 = 14;
    localparam int unsigned COLS  = 4;

    function automatic logic [3:0] last_round(input logic m256);
        return m256 ? 4'(NR256 - 1) : 4'(NR128 - 1);
    endfunction

endpackage

// File: rtl/aes_key_sched_cnt.sv
// Loadable down-counter with zero and one-before-zero flags; times the Sbox pipeline.
module aes_key_sched_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Control FSM for the 32-bit masked key datapath: key load, round-key generation
// (AES-128/256, forward/inverse) and Sbox arbitration with the state datapath.
module aes_key_sched_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_valid,
    output logic key_ready,
    input  logic mode_256,
    input  logic inverse,
    output logic sb_req,
    input  logic sb_grant,
    output logic rk_col_valid,
    output logic rk_last,
    output logic busy,
    output logic init,
    output logic enable_pipe_low,
    output logic enable_pipe_high,
    output logic loop,
    output logic add_from_sb,
    output logic rcon_rst,
    output logic rcon_mode_256,
    output logic rcon_update,
    output logic rcon_inverse,
    output logic enable_buffer_from_sbox,
    output logic rst_buffer_from_sbox,
    output logic disable_rot_rcon,
    output logic feedback_from_high,
    output logic col7_toSB,
    output logic mode_256_o
);

    ctrl_state_e r_state, w_state_nxt;
    logic [3:0]  r_rnd;
    logic [1:0]  r_cc;
    logic        r_m256, r_inv;
    logic        w_hs, w_rnd_clr, w_rnd_inc, w_cc_clr, w_cc_inc;
    logic        w_wc_load, w_wc_dec, w_wc_zero, w_wc_last;
    logic        w_odd, w_col_last, w_rnd_last;

    assign w_hs       = key_valid & key_ready;
    // AES-256 odd rounds take the high half of the key with no RotWord/Rcon.
    assign w_odd      = r_m256 & r_rnd[0];
    assign w_col_last = (r_cc == 2'(COLS - 1));
    assign w_rnd_last = (r_rnd == last_round(r_m256));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rnd   <= '0;
            r_cc    <= '0;
            r_m256  <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_m256 <= mode_256;
                r_inv  <= inverse;
            end
            if (w_rnd_clr) begin
                r_rnd <= '0;
            end else if (w_rnd_inc) begin
                r_rnd <= r_rnd + 1'b1;
            end
            if (w_cc_clr) begin
                r_cc <= '0;
            end else if (w_cc_inc) begin
                r_cc <= r_cc + 1'b1;
            end
        end
    end

    aes_key_sched_cnt #(
        .WIDTH (4)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_wc_load),
        .i_load_val (4'(SBOX_LAT - 1)),
        .i_dec      (w_wc_dec),
        .o_zero     (w_wc_zero),
        .o_last     (w_wc_last)
    );

    always_comb begin
        w_state_nxt             = r_state;
        w_rnd_clr               = 1'b0;
        w_rnd_inc               = 1'b0;
        w_cc_clr                = 1'b0;
        w_cc_inc                = 1'b0;
        w_wc_load               = 1'b0;
        w_wc_dec                = 1'b0;
        key_ready               = 1'b0;
        sb_req                  = 1'b0;
        rk_col_valid            = 1'b0;
        rk_last                 = 1'b0;
        init                    = 1'b0;
        enable_pipe_low         = 1'b0;
        enable_pipe_high        = 1'b0;
        loop                    = 1'b0;
        add_from_sb             = 1'b0;
        rcon_rst                = 1'b0;
        rcon_update             = 1'b0;
        enable_buffer_from_sbox = 1'b0;
        rst_buffer_from_sbox    = 1'b0;
        disable_rot_rcon        = 1'b0;
        feedback_from_high      = 1'b0;
        col7_toSB               = 1'b0;
        case (r_state)
            IDLE: begin
                key_ready = 1'b1;
                rcon_rst  = 1'b1;
                if (key_valid) begin
                    w_rnd_clr   = 1'b1;
                    w_cc_clr    = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                init                    = 1'b1;
                enable_pipe_low         = 1'b1;
                enable_pipe_high        = 1'b1;
                rst_buffer_from_sbox    = 1'b1;
                enable_buffer_from_sbox = 1'b1;
                w_state_nxt             = ISSUE;
            end
            ISSUE: begin
                sb_req    = 1'b1;
                col7_toSB = r_m256 & ~r_inv & (r_rnd == 4'd0);
                if (sb_grant) begin
                    if (SBOX_LAT <= 1) begin
                        w_state_nxt = UPDATE;
                    end else begin
                        w_wc_load   = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_wc_dec = 1'b1;
                if (w_wc_last || w_wc_zero) begin
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                rk_col_valid            = 1'b1;
                enable_pipe_low         = ~w_odd;
                enable_pipe_high        = w_odd;
                add_from_sb             = (r_cc == 2'd0);
                enable_buffer_from_sbox = r_inv;
                rst_buffer_from_sbox    = r_inv & (r_cc == 2'd0) & (r_rnd == 4'd0);
                disable_rot_rcon        = w_odd;
                feedback_from_high      = w_odd;
                w_cc_inc                = 1'b1;
                if (w_col_last) begin
                    rcon_update = ~w_odd;
                    if (w_rnd_last) begin
                        rk_last     = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_rnd_inc   = 1'b1;
                        w_state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                loop             = 1'b1;
                enable_pipe_low  = 1'b1;
                enable_pipe_high = r_m256;
                w_state_nxt      = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy          = (r_state != IDLE);
    assign rcon_mode_256 = r_m256;
    assign mode_256_o    = r_m256;
    assign rcon_inverse  = r_inv;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: per-column scoreboard plus per-scenario pulse counts and latency.
module tb_aes_key_sched_ctrl;

    logic clk = 1'b0;
    logic rst_n, key_valid, mode_256, inverse, sb_grant;
    logic key_ready, sb_req, rk_col_valid, rk_last, busy, init, enable_pipe_low;
    logic enable_pipe_high, loop, add_from_sb, rcon_rst, rcon_mode_256, rcon_update;
    logic rcon_inverse, enable_buffer_from_sbox, rst_buffer_from_sbox, disable_rot_rcon;
    logic feedback_from_high, col7_toSB, mode_256_o;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.SBOX_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .mode_256(mode_256), .inverse(inverse), .sb_req(sb_req), .sb_grant(sb_grant),
        .rk_col_valid(rk_col_valid), .rk_last(rk_last), .busy(busy), .init(init),
        .enable_pipe_low(enable_pipe_low), .enable_pipe_high(enable_pipe_high), .loop(loop),
        .add_from_sb(add_from_sb), .rcon_rst(rcon_rst), .rcon_mode_256(rcon_mode_256),
        .rcon_update(rcon_update), .rcon_inverse(rcon_inverse),
        .enable_buffer_from_sbox(enable_buffer_from_sbox),
        .rst_buffer_from_sbox(rst_buffer_from_sbox), .disable_rot_rcon(disable_rot_rcon),
        .feedback_from_high(feedback_from_high), .col7_toSB(col7_toSB),
        .mode_256_o(mode_256_o)
    );

    logic [19:0] obs;
    assign obs = {key_ready, sb_req, rk_col_valid, rk_last, busy, init, enable_pipe_low,
                  enable_pipe_high, loop, add_from_sb, rcon_rst, rcon_mode_256, rcon_update,
                  rcon_inverse, enable_buffer_from_sbox, rst_buffer_from_sbox,
                  disable_rot_rcon, feedback_from_high, col7_toSB, mode_256_o};
    localparam logic [19:0] ObsReset = 20'h80200;  // key_ready and rcon_rst only

    logic [8:0] col_obs;
    assign col_obs = {rk_last, add_from_sb, enable_pipe_low, enable_pipe_high, disable_rot_rcon,
                      feedback_from_high, rcon_update, enable_buffer_from_sbox,
                      rst_buffer_from_sbox};

    logic [8:0] sb_q[$];
    int checks = 0;
    int errors = 0;
    int n_col, n_rcon, n_add, n_last, n_dis, n_fb, n_col7, n_col7_bad, n_load_ok, n_loop;
    int n_loop_hi, n_inv_low, n_bufen, n_rstbuf_load, n_kr_busy, n_cfg_bad;
    int n_stall_req, n_stall_upd, lat, g_cnt;
    logic cur_m, cur_iv;

    // Pushes the expected per-column strobes, performs the handshake and runs the schedule,
    // popping one expectation per rk_col_valid cycle.
    task automatic run_key(input logic m, input logic iv, input int stall_rnd,
                           input int stall_len, input bit hold_kv, input int stop_g);
        int nr, stalled;
        logic odd, took;
        logic [8:0] e;
        nr = m ? 14 : 10;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < 4; c++) begin
                odd = m & (r % 2 == 1);
                e = {(r == nr - 1) && (c == 3), c == 0, ~odd, odd, odd, odd,
                     (c == 3) && !odd, iv, iv && (c == 0) && (r == 0)};
                sb_q.push_back(e);
            end
        end
        {n_col, n_rcon, n_add, n_last, n_dis, n_fb, n_col7, n_col7_bad, n_load_ok} = '0;
        {n_loop, n_loop_hi, n_inv_low, n_bufen, n_rstbuf_load, n_kr_busy, n_cfg_bad} = '0;
        {n_stall_req, n_stall_upd} = '0;
        cur_m = m; cur_iv = iv; g_cnt = 0; lat = 0; stalled = 0;
        mode_256 = m; inverse = iv; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = hold_kv; mode_256 = ~m; inverse = ~iv;
        while (busy && lat < 2000 && !(stop_g != 0 && g_cnt >= stop_g)) begin
            if (rk_col_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL col_extra got column %0d, expected none", n_col);
                end else begin
                    e = sb_q.pop_front();
                    if (col_obs !== e) begin
                        errors++;
                        $display("FAIL col_strobes col %0d got %b exp %b", n_col, col_obs, e);
                    end
                end
            end
            n_col += int'(rk_col_valid);
            n_rcon += int'(rcon_update);
            n_add += int'(add_from_sb);
            n_last += int'(rk_last);
            n_dis += int'(disable_rot_rcon);
            n_fb += int'(feedback_from_high);
            n_col7 += int'(col7_toSB);
            if (col7_toSB && g_cnt != 0) n_col7_bad++;
            if (init && enable_pipe_low && enable_pipe_high && rst_buffer_from_sbox
                && enable_buffer_from_sbox) n_load_ok++;
            n_loop += int'(loop);
            if (loop && enable_pipe_high) n_loop_hi++;
            if (!rcon_inverse) n_inv_low++;
            n_bufen += int'(rk_col_valid & enable_buffer_from_sbox);
            n_rstbuf_load += int'(init & rst_buffer_from_sbox);
            n_kr_busy += int'(key_ready);
            if (rcon_mode_256 !== cur_m || mode_256_o !== cur_m || rcon_inverse !== cur_iv)
                n_cfg_bad++;
            if (sb_req && g_cnt == stall_rnd && stalled < stall_len) begin
                sb_grant = 1'b0;
                stalled++;
            end else begin
                sb_grant = 1'b1;
            end
            took = sb_req & sb_grant;
            if (!sb_grant) begin
                n_stall_req += int'(sb_req);
                n_stall_upd += int'(rk_col_valid | rcon_update | add_from_sb);
            end
            @(posedge clk); #1;
            lat++;
            if (took) g_cnt++;
        end
        sb_grant = 1'b1;
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (obs !== ObsReset) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", obs, ObsReset);
        end
    endtask

    task automatic test_aes128_fwd();
        run_key(1'b0, 1'b0, -1, 0, 1'b0, 0);
        checks++; if (n_col !== 40) begin errors++; $display("FAIL a128_cols got %0d exp 40", n_col); end
        checks++; if (n_rcon !== 10) begin errors++; $display("FAIL a128_rcon got %0d exp 10", n_rcon); end
        checks++; if (n_add !== 10) begin errors++; $display("FAIL a128_add got %0d exp 10", n_add); end
        checks++; if (n_last !== 1) begin errors++; $display("FAIL a128_last got %0d exp 1", n_last); end
        checks++; if (lat !== 82) begin errors++; $display("FAIL a128_latency got %0d exp 82", lat); end
        checks++; if (n_load_ok !== 1) begin errors++; $display("FAIL a128_load got %0d exp 1", n_load_ok); end
        checks++; if (n_loop !== 1 || n_loop_hi !== 0) begin
            errors++; $display("FAIL a128_done got loop %0d hi %0d exp 1 0", n_loop, n_loop_hi); end
        checks++; if (n_cfg_bad !== 0) begin errors++; $display("FAIL a128_cfg got %0d exp 0", n_cfg_bad); end
        checks++; if (sb_q.size() !== 0) begin
            errors++; $display("FAIL a128_sb_left got %0d exp 0", sb_q.size()); end
    endtask

    task automatic test_aes256_fwd();
        run_key(1'b1, 1'b0, -1, 0, 1'b0, 0);
        checks++; if (n_col !== 56) begin errors++; $display("FAIL a256_cols got %0d exp 56", n_col); end
        checks++; if (n_rcon !== 7) begin errors++; $display("FAIL a256_rcon got %0d exp 7", n_rcon); end
        checks++; if (n_dis !== 28 || n_fb !== 28) begin
            errors++; $display("FAIL a256_odd got dis %0d fb %0d exp 28 28", n_dis, n_fb); end
        checks++; if (n_col7 !== 1 || n_col7_bad !== 0) begin
            errors++; $display("FAIL a256_col7 got %0d bad %0d exp 1 0", n_col7, n_col7_bad); end
        checks++; if (lat !== 114) begin errors++; $display("FAIL a256_latency got %0d exp 114", lat); end
        checks++; if (n_loop_hi !== 1) begin errors++; $display("FAIL a256_done_hi got %0d exp 1", n_loop_hi); end
        checks++; if (n_cfg_bad !== 0) begin errors++; $display("FAIL a256_cfg got %0d exp 0", n_cfg_bad); end
        checks++; if (sb_q.size() !== 0) begin
            errors++; $display("FAIL a256_sb_left got %0d exp 0", sb_q.size()); end
    endtask

    task automatic test_grant_stall();
        run_key(1'b0, 1'b0, 3, 5, 1'b0, 0);
        checks++; if (lat !== 87) begin errors++; $display("FAIL stall_latency got %0d exp 87", lat); end
        checks++; if (n_stall_req !== 5) begin errors++; $display("FAIL stall_req got %0d exp 5", n_stall_req); end
        checks++; if (n_stall_upd !== 0) begin errors++; $display("FAIL stall_upd got %0d exp 0", n_stall_upd); end
        checks++; if (n_col !== 40) begin errors++; $display("FAIL stall_cols got %0d exp 40", n_col); end
    endtask

    task automatic test_inverse128();
        run_key(1'b0, 1'b1, -1, 0, 1'b0, 0);
        checks++; if (n_inv_low !== 0) begin errors++; $display("FAIL inv_rcon got %0d exp 0", n_inv_low); end
        checks++; if (n_bufen !== 40) begin errors++; $display("FAIL inv_bufen got %0d exp 40", n_bufen); end
        checks++; if (n_rstbuf_load !== 1) begin
            errors++; $display("FAIL inv_rstbuf_load got %0d exp 1", n_rstbuf_load); end
        checks++; if (n_col7 !== 0) begin errors++; $display("FAIL inv_col7 got %0d exp 0", n_col7); end
        checks++; if (lat !== 82) begin errors++; $display("FAIL inv_latency got %0d exp 82", lat); end
    endtask

    task automatic test_reset_mid();
        run_key(1'b1, 1'b1, -1, 0, 1'b0, 6);
        checks++; if ({busy, sb_req, rk_col_valid} !== 3'b100) begin
            errors++; $display("FAIL mid_wait got %b exp 100", {busy, sb_req, rk_col_valid}); end
        rst_n = 1'b0;
        #1;
        checks++; if (obs !== ObsReset) begin
            errors++; $display("FAIL mid_reset got %h exp %h", obs, ObsReset); end
        sb_q.delete();
        key_valid = 1'b1; mode_256 = 1'b1; inverse = 1'b1;
        @(posedge clk); #1;
        checks++; if (obs !== ObsReset) begin
            errors++; $display("FAIL reset_wins got %h exp %h", obs, ObsReset); end
        key_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_key(1'b0, 1'b0, -1, 0, 1'b0, 0);
        checks++; if (n_col !== 40 || lat !== 82) begin
            errors++; $display("FAIL restart got cols %0d lat %0d exp 40 82", n_col, lat); end
    endtask

    task automatic test_back_to_back();
        run_key(1'b0, 1'b1, -1, 0, 1'b1, 0);
        checks++; if (n_kr_busy !== 0) begin errors++; $display("FAIL busy_ready got %0d exp 0", n_kr_busy); end
        checks++; if (n_cfg_bad !== 0) begin errors++; $display("FAIL busy_relatch got %0d exp 0", n_cfg_bad); end
        checks++; if (lat !== 82) begin errors++; $display("FAIL b2b_lat1 got %0d exp 82", lat); end
        run_key(1'b1, 1'b0, -1, 0, 1'b0, 0);
        checks++; if (lat !== 114 || n_cfg_bad !== 0) begin
            errors++; $display("FAIL b2b_second got lat %0d cfg %0d exp 114 0", lat, n_cfg_bad); end
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; mode_256 = 1'b0; inverse = 1'b0; sb_grant = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_aes128_fwd();
        test_aes256_fwd();
        test_grant_stall();
        test_inverse128();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
